seg_write_back: RTL and testbench

SEG_WRITE_BACK -- requirements
Module: seg_write_back

---
 rtl/seg_write_back_pkg.sv | 15 +
 rtl/seg_write_back_load_formatter.sv | 25 ++
 rtl/seg_write_back.sv | 88 ++++++++
 tb/tb_seg_write_back.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_write_back_pkg.sv
// Shared MIPS datapath parameters: widths, WB control bus bit positions and
// load-format bit positions used by the write-back stage.
package seg_write_back_pkg;
    localparam int MIPS_LEN        = 32;
    localparam int MIPS_NB_ADDR    = 5;
    localparam int MIPS_NB_CTRL_WB = 2;
    localparam int NB_FMT          = 3;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int FMT_LB  = 2;
    localparam int FMT_LH  = 1;
    localparam int FMT_UNS = 0;
endpackage

// File: rtl/seg_write_back_load_formatter.sv
// Load lane select and sign/zero extension for LB/LH/LBU/LHU/LW.
module load_formatter
    import seg_write_back_pkg::*;
#(
    parameter int LEN = MIPS_LEN
) (
    input  logic [LEN-1:0]    word,
    input  logic [1:0]        lane,
    input  logic [NB_FMT-1:0] fmt,
    output logic [LEN-1:0]    data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Little-endian lanes; lane[0] is ignored for halfwords (no alignment trap).
    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        data   = word;
        if (fmt[FMT_LB])
            data = fmt[FMT_UNS] ? LEN'(byte_v) : {{(LEN-8){byte_v[7]}}, byte_v};
        else if (fmt[FMT_LH])
            data = fmt[FMT_UNS] ? LEN'(half_v) : {{(LEN-16){half_v[15]}}, half_v};
    end
endmodule

// File: rtl/seg_write_back.sv
// MEM/WB pipeline register plus write-back data select and retire counter.
module seg_write_back
    import seg_write_back_pkg::*;
#(
    parameter int LEN        = MIPS_LEN,
    parameter int NB_ADDR    = MIPS_NB_ADDR,
    parameter int NB_CTRL_WB = MIPS_NB_CTRL_WB
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [2:0]            i_load_fmt,
    input  logic                  i_link,
    input  logic [LEN-1:0]        i_PC,
    input  logic [LEN-1:0]        i_read_data,
    input  logic [LEN-1:0]        i_alu_result,
    input  logic [NB_ADDR-1:0]    i_write_reg,
    input  logic                  i_count_clr,
    output logic [NB_ADDR-1:0]    o_write_reg,
    output logic [LEN-1:0]        o_write_data,
    output logic                  o_RegWrite,
    output logic                  o_valid,
    output logic [31:0]           o_retired_count
);
    logic                  valid_q;
    logic [NB_CTRL_WB-1:0] ctrl_q;
    logic [2:0]            fmt_q;
    logic                  link_q;
    logic [LEN-1:0]        pc_q;
    logic [LEN-1:0]        rdata_q;
    logic [LEN-1:0]        alu_q;
    logic [NB_ADDR-1:0]    wreg_q;
    logic [31:0]           retired_q;
    logic [LEN-1:0]        load_data;

    // A flush only kills valid/RegWrite; the rest of the payload is don't-care.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            fmt_q   <= '0;
            link_q  <= 1'b0;
            pc_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
        end else if (i_flush) begin
            valid_q              <= 1'b0;
            ctrl_q[WB_REGWRITE]  <= 1'b0;
        end else if (!i_stall) begin
            valid_q <= i_valid;
            ctrl_q  <= i_ctrl_wb_bus;
            fmt_q   <= i_load_fmt;
            link_q  <= i_link;
            pc_q    <= i_PC;
            rdata_q <= i_read_data;
            alu_q   <= i_alu_result;
            wreg_q  <= i_write_reg;
        end
    end

    // An instruction retires on the edge it leaves WB, i.e. valid and not held.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            retired_q <= '0;
        else if (i_count_clr)
            retired_q <= '0;
        else if (valid_q && !i_stall)
            retired_q <= retired_q + 32'd1;
    end

    load_formatter #(.LEN(LEN)) u_load_formatter (
        .word (rdata_q),
        .lane (alu_q[1:0]),
        .fmt  (fmt_q),
        .data (load_data)
    );

    assign o_write_reg     = wreg_q;
    assign o_valid         = valid_q;
    assign o_RegWrite      = valid_q & ctrl_q[WB_REGWRITE] & (wreg_q != '0);
    assign o_write_data    = link_q              ? pc_q      :
                             ctrl_q[WB_MEMTOREG] ? load_data : alu_q;
    assign o_retired_count = retired_q;
endmodule

// File: tb/tb_seg_write_back.sv
// Randomized bench for seg_write_back against a transaction-level reference model.
module tb_seg_write_back;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
    logic [1:0]  i_ctrl_wb_bus = '0;
    logic [2:0]  i_load_fmt = '0;
    logic        i_link = 1'b0;
    logic [31:0] i_PC = '0, i_read_data = '0, i_alu_result = '0;
    logic [4:0]  i_write_reg = '0;
    logic        i_count_clr = 1'b0;
    logic [4:0]  o_write_reg;
    logic [31:0] o_write_data;
    logic        o_RegWrite, o_valid;
    logic [31:0] o_retired_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: the instruction sitting in WB, and the retire count.
    logic        m_valid, m_rw, m_mtr, m_link;
    logic [2:0]  m_fmt;
    logic [31:0] m_pc, m_word, m_alu, m_cnt;
    logic [4:0]  m_wreg;

    seg_write_back dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_load_fmt(i_load_fmt),
        .i_link(i_link), .i_PC(i_PC), .i_read_data(i_read_data),
        .i_alu_result(i_alu_result), .i_write_reg(i_write_reg),
        .i_count_clr(i_count_clr), .o_write_reg(o_write_reg),
        .o_write_data(o_write_data), .o_RegWrite(o_RegWrite), .o_valid(o_valid),
        .o_retired_count(o_retired_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data();
        logic [31:0] v;
        int a;
        if (m_link) return m_pc;
        if (!m_mtr) return m_alu;
        a = int'(m_alu & 32'd3);
        if (m_fmt[2]) begin
            v = (m_word >> (8 * a)) & 32'hFF;
            if (!m_fmt[0] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (m_fmt[1]) begin
            v = (m_word >> (16 * (a / 2))) & 32'hFFFF;
            if (!m_fmt[0] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = m_word;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_link = 0; m_fmt = '0;
        m_pc = '0; m_word = '0; m_alu = '0; m_wreg = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [31:0] nc;
        nc = i_count_clr ? 32'd0 : (m_valid && !i_stall) ? m_cnt + 32'd1 : m_cnt;
        if (i_flush) begin
            m_valid = 0; m_rw = 0;
        end else if (!i_stall) begin
            m_valid = i_valid; m_rw = i_ctrl_wb_bus[1]; m_mtr = i_ctrl_wb_bus[0];
            m_fmt = i_load_fmt; m_link = i_link; m_pc = i_PC;
            m_word = i_read_data; m_alu = i_alu_result; m_wreg = i_write_reg;
        end
        m_cnt = nc;
    endtask

    task automatic compare_all();
        check("valid", 32'(o_valid), 32'(m_valid));
        check("regwrite", 32'(o_RegWrite), 32'(m_valid && m_rw && m_wreg != 0));
        if (m_valid) begin
            check("write_reg", 32'(o_write_reg), 32'(m_wreg));
            check("write_data", o_write_data, exp_data());
        end
        check("count", o_retired_count, m_cnt);
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [2:0] fmt,
                         input logic lnk, input logic [31:0] pc, input logic [31:0] word,
                         input logic [31:0] alu, input logic [4:0] wreg);
        i_valid = v; i_ctrl_wb_bus = {rw, mtr}; i_load_fmt = fmt; i_link = lnk;
        i_PC = pc; i_read_data = word; i_alu_result = alu; i_write_reg = wreg;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_regwrite"}, 32'(o_RegWrite), 32'd0);
        check({tag, "_wreg"}, 32'(o_write_reg), 32'd0);
        check({tag, "_wdata"}, o_write_data, 32'd0);
        check({tag, "_count"}, o_retired_count, 32'd0);
    endtask

    initial begin
        model_reset();
        drive(1, 1, 1, 3'b100, 1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h3, 5'd7);
        repeat (2) @(posedge i_clk);
        #1 check_reset_outputs("rst");
        @(negedge i_clk) i_rst = 1'b1;

        // LB signed, two lanes
        drive(1, 1, 1, 3'b100, 0, 32'h0, 32'h80FF_7F01, 32'h2, 5'd3);
        cycle(); check("lb_lane2", o_write_data, 32'hFFFF_FFFF);
        drive(1, 1, 1, 3'b100, 0, 32'h0, 32'h80FF_7F01, 32'h1, 5'd3);
        cycle(); check("lb_lane1", o_write_data, 32'h0000_007F);
        // LHU, alu[0] ignored
        drive(1, 1, 1, 3'b011, 0, 32'h0, 32'h8001_ABCD, 32'h2, 5'd4);
        cycle(); check("lhu_a2", o_write_data, 32'h0000_8001);
        drive(1, 1, 1, 3'b011, 0, 32'h0, 32'h8001_ABCD, 32'h3, 5'd4);
        cycle(); check("lhu_a3", o_write_data, 32'h0000_8001);
        // JAL
        drive(1, 1, 0, 3'b000, 1, 32'h0000_0040, 32'h5555_5555, 32'h9999, 5'd31);
        cycle(); check("jal_data", o_write_data, 32'h0000_0040);
        check("jal_rw", 32'(o_RegWrite), 32'd1);
        // write to r0 suppressed but still retires
        drive(1, 1, 0, 3'b000, 0, 32'h0, 32'h0, 32'h1234, 5'd0);
        cycle(); check("r0_rw", 32'(o_RegWrite), 32'd0);
        check("r0_data", o_write_data, 32'h0000_1234);
        begin
            logic [31:0] c0;
            c0 = o_retired_count;
            // stall and flush together: bubble, and nothing retires next edge
            drive(1, 1, 0, 3'b000, 0, 32'h0, 32'h0, 32'h77, 5'd9);
            i_stall = 1; i_flush = 1;
            cycle(); check("sf_valid", 32'(o_valid), 32'd0);
            check("sf_cnt_hold", o_retired_count, c0);
            i_stall = 0; i_flush = 0;
            cycle(); check("sf_cnt_next", o_retired_count, c0);
        end
        // counter wrap via preload, then clear with a valid retire
        force dut.retired_q = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        m_cnt = 32'hFFFF_FFFF;
        cycle(); check("wrap", o_retired_count, 32'd0);
        i_count_clr = 1;
        cycle(); check("clr", o_retired_count, 32'd0);
        i_count_clr = 0;

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(3) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  $urandom_range(6) == 0, $urandom, $urandom, $urandom,
                  $urandom_range(4) == 0 ? 5'd0 : 5'($urandom));
            i_stall     = $urandom_range(4) == 0;
            i_flush     = $urandom_range(9) == 0;
            i_count_clr = $urandom_range(30) == 0;
            cycle();
        end
        i_stall = 0; i_flush = 0; i_count_clr = 0;

        // reset mid-instruction: discarded and not counted
        drive(1, 1, 0, 3'b000, 0, 32'h0, 32'h0, 32'hABCD, 5'd6);
        cycle();
        #2 i_rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        @(posedge i_clk);
        #1 check_reset_outputs("hold_rst");
        @(negedge i_clk) i_rst = 1'b1;
        drive(0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle(); check("post_rst_cnt", o_retired_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule
